// File: rtl/mem32_access_arbiter_if.sv
// Bundle of requester, clear-control and memory-side signals around the 32-byte memory arbiter.
// The slave view belongs to the arbiter; the master view to requesters plus the memory.
interface mem32_access_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              req_a;
  logic              we_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              req_b;
  logic              we_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b;
  logic              ack_a;
  logic              ack_b;
  logic [DATA_W-1:0] rdata;
  logic              clr_start;
  logic              clr_done;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_I;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_O;

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    input  clr_start, mem_O,
    output ack_a, ack_b, rdata, clr_done, busy,
    output mem_addr, mem_I, mem_read, mem_write
  );

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    output clr_start, mem_O,
    input  ack_a, ack_b, rdata, clr_done, busy,
    input  mem_addr, mem_I, mem_read, mem_write
  );
endinterface

// File: rtl/mem32_access_arbiter.sv
// Round-robin arbiter for two requesters onto a shared single-port memory, with a
// self-timed clear sequencer. Every output, including the memory controls, is a register.
module mem32_access_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  mem32_access_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ACCESS, ACK, CLEAR, CDONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state_reg, state_next;
  logic              last_grant_reg, last_grant_next;  // 1 = B granted last
  logic              owner_reg, owner_next;            // 1 = B owns the access
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_i_reg, mem_i_next;
  logic              mem_read_reg, mem_read_next;
  logic              mem_write_reg, mem_write_next;
  logic              ack_a_reg, ack_a_next;
  logic              ack_b_reg, ack_b_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              clr_done_reg, clr_done_next;
  logic              busy_reg, busy_next;
  logic              pick_b;
  logic              we_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      cnt_reg        <= '0;
      mem_addr_reg   <= '0;
      mem_i_reg      <= '0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      ack_a_reg      <= 1'b0;
      ack_b_reg      <= 1'b0;
      rdata_reg      <= '0;
      clr_done_reg   <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      owner_reg      <= owner_next;
      cnt_reg        <= cnt_next;
      mem_addr_reg   <= mem_addr_next;
      mem_i_reg      <= mem_i_next;
      mem_read_reg   <= mem_read_next;
      mem_write_reg  <= mem_write_next;
      ack_a_reg      <= ack_a_next;
      ack_b_reg      <= ack_b_next;
      rdata_reg      <= rdata_next;
      clr_done_reg   <= clr_done_next;
      busy_reg       <= busy_next;
    end
  end

  // Next-state logic also computes the value each output register takes in the next state.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    owner_next      = owner_reg;
    cnt_next        = cnt_reg;
    mem_addr_next   = mem_addr_reg;
    mem_i_next      = mem_i_reg;
    mem_read_next   = 1'b0;
    mem_write_next  = 1'b0;
    ack_a_next      = 1'b0;
    ack_b_next      = 1'b0;
    rdata_next      = rdata_reg;
    clr_done_next   = 1'b0;
    pick_b          = 1'b0;
    we_sel          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.clr_start) begin
          state_next     = CLEAR;
          cnt_next       = '0;
          mem_addr_next  = '0;
          mem_i_next     = '0;
          mem_write_next = 1'b1;
        end else if (bus.req_a || bus.req_b) begin
          // On a tie the requester that did not win last time is granted.
          pick_b          = bus.req_b && (!bus.req_a || !last_grant_reg);
          we_sel          = pick_b ? bus.we_b : bus.we_a;
          owner_next      = pick_b;
          last_grant_next = pick_b;
          mem_addr_next   = pick_b ? bus.addr_b : bus.addr_a;
          mem_write_next  = we_sel;
          mem_read_next   = !we_sel;
          if (we_sel) begin
            mem_i_next = pick_b ? bus.wdata_b : bus.wdata_a;
          end
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        // mem_O is only sampled while the memory is actively driving it.
        if (mem_read_reg) begin
          rdata_next = bus.mem_O;
        end
        ack_a_next = !owner_reg;
        ack_b_next = owner_reg;
        state_next = ACK;
      end
      ACK: begin
        state_next = IDLE;
      end
      CLEAR: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST_ADDR) begin
          clr_done_next = 1'b1;
          state_next    = CDONE;
        end else begin
          mem_addr_next  = cnt_reg + 1'b1;
          mem_write_next = 1'b1;
        end
      end
      CDONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy_next = (state_next != IDLE);

  assign bus.ack_a     = ack_a_reg;
  assign bus.ack_b     = ack_b_reg;
  assign bus.rdata     = rdata_reg;
  assign bus.clr_done  = clr_done_reg;
  assign bus.busy      = busy_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_I     = mem_i_reg;
  assign bus.mem_read  = mem_read_reg;
  assign bus.mem_write = mem_write_reg;

endmodule

// File: tb/tb_mem32_access_arbiter.sv
// Directed bench for mem32_access_arbiter with a behavioural 32-byte tri-state memory.
module tb_mem32_access_arbiter;

  logic clk;
  logic reset;
  logic mem_fill;
  logic [7:0] mem [32];
  int checks;
  int failures;

  mem32_access_arbiter_if #(.ADDR_W(5), .DATA_W(8)) bus ();

  mem32_access_arbiter #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: writes land on the edge regardless of reset; output floats unless read.
  always @(posedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'hFF;
    end else if (bus.mem_write) begin
      mem[bus.mem_addr] <= bus.mem_I;
    end
  end

  assign bus.mem_O = bus.mem_read ? mem[bus.mem_addr] : 8'hzz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction; returns with the arbiter back in IDLE.
  task automatic access(input bit who_b, input bit we, input logic [4:0] addr,
                        input logic [7:0] wd, output logic [7:0] rd);
    bit got;
    got = 1'b0;
    if (who_b) begin
      bus.req_b = 1'b1; bus.we_b = we; bus.addr_b = addr; bus.wdata_b = wd;
    end else begin
      bus.req_a = 1'b1; bus.we_a = we; bus.addr_a = addr; bus.wdata_a = wd;
    end
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      if (who_b ? bus.ack_b : bus.ack_a) got = 1'b1;
    end
    check(who_b ? "ack_b_timeout" : "ack_a_timeout", got, 1'b1);
    rd = bus.rdata;
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    $display("txn %s %s addr=%0d wdata=%0h rdata=%0h", who_b ? "B" : "A",
             we ? "write" : "read", addr, wd, rd);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    bit bad;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    mem_fill = 1'b1;
    bus.req_a = 0; bus.we_a = 0; bus.addr_a = 0; bus.wdata_a = 0;
    bus.req_b = 0; bus.we_b = 0; bus.addr_b = 0; bus.wdata_b = 0;
    bus.clr_start = 0;
    repeat (3) tick();
    mem_fill = 1'b0;

    check("rst_busy", bus.busy, 0);
    check("rst_ack_a", bus.ack_a, 0);
    check("rst_ack_b", bus.ack_b, 0);
    check("rst_mem_write", bus.mem_write, 0);
    check("rst_mem_read", bus.mem_read, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_I", bus.mem_I, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_clr_done", bus.clr_done, 0);
    reset = 1'b0;

    // A write 5 <- A5 with exact cycle timing
    bus.req_a = 1; bus.we_a = 1; bus.addr_a = 5; bus.wdata_a = 8'hA5;
    tick();
    check("w1_mem_write", bus.mem_write, 1);
    check("w1_mem_read", bus.mem_read, 0);
    check("w1_mem_addr", bus.mem_addr, 5);
    check("w1_mem_I", bus.mem_I, 8'hA5);
    check("w1_ack_a_c1", bus.ack_a, 0);
    check("w1_busy", bus.busy, 1);
    tick();
    check("w1_ack_a_c2", bus.ack_a, 1);
    check("w1_mem_write_c2", bus.mem_write, 0);
    bus.req_a = 0;
    tick();
    check("w1_ack_a_c3", bus.ack_a, 0);
    check("w1_mem5", mem[5], 8'hA5);
    $display("txn A write addr=5 wdata=a5");

    // A read of 5
    bus.req_a = 1; bus.we_a = 0; bus.addr_a = 5;
    tick();
    check("r1_mem_read", bus.mem_read, 1);
    check("r1_mem_write", bus.mem_write, 0);
    check("r1_mem_addr", bus.mem_addr, 5);
    tick();
    check("r1_ack_a", bus.ack_a, 1);
    check("r1_ack_b", bus.ack_b, 0);
    check("r1_rdata", bus.rdata, 8'hA5);
    check("r1_mem_read_c2", bus.mem_read, 0);
    bus.req_a = 0;
    tick();
    check("r1_ack_a_c3", bus.ack_a, 0);
    check("r1_ack_b_c3", bus.ack_b, 0);
    check("r1_rdata_hold", bus.rdata, 8'hA5);
    $display("txn A read addr=5 rdata=%0h", bus.rdata);

    // B access so that A wins the following tie
    access(1'b1, 1'b1, 5'd0, 8'h3C, rd);

    // Continuous contention: A at 2, B at 5, A at 8, B at 11
    bus.req_a = 1; bus.we_a = 1; bus.addr_a = 10; bus.wdata_a = 8'h11;
    bus.req_b = 1; bus.we_b = 1; bus.addr_b = 20; bus.wdata_b = 8'h22;
    for (int t = 1; t <= 12; t++) begin
      tick();
      check($sformatf("rr_ack_a_t%0d", t), bus.ack_a, (t == 2 || t == 8) ? 1 : 0);
      check($sformatf("rr_ack_b_t%0d", t), bus.ack_b, (t == 5 || t == 11) ? 1 : 0);
      if (t == 11) begin
        bus.req_a = 0;
        bus.req_b = 0;
      end
    end
    check("rr_mem10", mem[10], 8'h11);
    check("rr_mem20", mem[20], 8'h22);
    $display("txn AB contention four grants");

    // Clear with simultaneous B request; clear wins
    access(1'b0, 1'b1, 5'd31, 8'h3C, rd);
    access(1'b1, 1'b1, 5'd0, 8'h3C, rd);
    bus.clr_start = 1;
    bus.req_b = 1; bus.we_b = 0; bus.addr_b = 0;
    for (int t = 1; t <= 32; t++) begin
      tick();
      bus.clr_start = 0;
      check($sformatf("clr_write_t%0d", t), bus.mem_write, 1);
      check($sformatf("clr_addr_t%0d", t), bus.mem_addr, t - 1);
      check($sformatf("clr_data_t%0d", t), bus.mem_I, 0);
      check($sformatf("clr_ack_b_t%0d", t), bus.ack_b, 0);
    end
    tick();
    check("clr_done_pulse", bus.clr_done, 1);
    check("clr_write_off", bus.mem_write, 0);
    check("clr_busy_cdone", bus.busy, 1);
    tick();
    check("clr_done_clear", bus.clr_done, 0);
    check("clr_idle_busy", bus.busy, 0);
    tick();
    check("clr_b_read", bus.mem_read, 1);
    check("clr_b_addr", bus.mem_addr, 0);
    tick();
    check("clr_b_ack", bus.ack_b, 1);
    check("clr_b_rdata0", bus.rdata, 0);
    bus.req_b = 0;
    tick();
    $display("txn clear then B read addr=0 rdata=%0h", bus.rdata);
    access(1'b1, 1'b0, 5'd31, 8'h00, rd);
    check("clr_b_rdata31", rd, 0);
    check("clr_mem20", mem[20], 0);

    // Reset in the 10th clear cycle
    access(1'b0, 1'b1, 5'd9, 8'h77, rd);
    access(1'b0, 1'b1, 5'd10, 8'h77, rd);
    bus.clr_start = 1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      bus.clr_start = 0;
    end
    check("mrst_clr_addr", bus.mem_addr, 9);
    reset = 1;
    tick();
    check("mrst_busy", bus.busy, 0);
    check("mrst_mem_write", bus.mem_write, 0);
    check("mrst_mem_addr", bus.mem_addr, 0);
    check("mrst_mem_I", bus.mem_I, 0);
    check("mrst_clr_done", bus.clr_done, 0);
    reset = 0;
    bad = 0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (bus.clr_done || bus.mem_write || bus.busy) bad = 1;
    end
    check("mrst_no_resume", bad, 0);
    check("mrst_mem9", mem[9], 0);
    check("mrst_mem10", mem[10], 8'h77);
    $display("txn reset during clear");

    // Reset during ACCESS of a read
    access(1'b0, 1'b0, 5'd10, 8'h00, rd);
    check("arst_pre_rdata", rd, 8'h77);
    bus.req_a = 1; bus.we_a = 0; bus.addr_a = 10;
    tick();
    check("arst_mem_read", bus.mem_read, 1);
    reset = 1;
    bus.req_a = 0;
    tick();
    check("arst_rdata", bus.rdata, 0);
    check("arst_ack_a", bus.ack_a, 0);
    check("arst_mem_read_off", bus.mem_read, 0);
    check("arst_busy", bus.busy, 0);
    reset = 0;
    bad = 0;
    for (int t = 0; t < 5; t++) begin
      tick();
      if (bus.ack_a || bus.ack_b || bus.busy) bad = 1;
    end
    check("arst_no_ack", bad, 0);
    $display("txn reset during read access");
    access(1'b0, 1'b1, 5'd31, 8'h5A, rd);
    access(1'b0, 1'b0, 5'd31, 8'h00, rd);
    check("arst_after_rdata", rd, 8'h5A);

    // Boundary addresses back to back
    access(1'b0, 1'b1, 5'd31, 8'hC3, rd);
    access(1'b1, 1'b1, 5'd0, 8'h3C, rd);
    access(1'b0, 1'b0, 5'd31, 8'h00, rd);
    check("bnd_rd31", rd, 8'hC3);
    access(1'b1, 1'b0, 5'd0, 8'h00, rd);
    check("bnd_rd0", rd, 8'h3C);
    check("bnd_mem31", mem[31], 8'hC3);
    check("bnd_mem0", mem[0], 8'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
